// File: rtl/hfc_pkg.sv
// ---- hfc_pkg : shared types/constants for hazard_flush_ctrl ---- rev 1.0
`default_nettype none

package hfc_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    TRAP_DRAIN    = 2'd1,
    TRAP_REDIRECT = 2'd2
  } hfc_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    LOAD_USE = 2'd1,
    BJ       = 2'd2,
    EXC      = 2'd3
  } hazard_cause_e;

  function automatic logic load_use_hit(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2
  );
    return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

`default_nettype wire

// File: rtl/hfc_perf_counter.sv
// ---- hfc_perf_counter : saturating event counter (level or rising-edge) ---- rev 1.0
`default_nettype none

module hfc_perf_counter #(
  parameter int CNT_W     = 32,
  parameter bit EDGE_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             event_in,
  output logic [CNT_W-1:0] count
);

  logic prev_event;
  logic fire;

  assign fire = EDGE_MODE ? (event_in & ~prev_event) : event_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_event <= 1'b0;
      count      <= '0;
    end else begin
      prev_event <= event_in;
      if (fire && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_flush_ctrl.sv
// ---- hazard_flush_ctrl : load-use / branch / trap pipeline sequencer ---- rev 1.0
// ---- Optional perf counters enabled by defining HFC_PERF_CNT_EN.
`default_nettype none

module hazard_flush_ctrl
  import hfc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              DRAIN_CYCLES = 2,
  parameter int              CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_is_bj,
  input  logic                  ex_bj_taken,
  input  logic [XLEN-1:0]       ex_bj_target,
  input  logic                  mem_exception,
  input  logic [XLEN-1:0]       mem_pc,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  flush_mem,
  output logic                  pc_redirect,
  output logic [XLEN-1:0]       pc_redirect_addr,
  output logic [XLEN-1:0]       epc,
  output logic                  debug_flush,
  output logic                  debug_is_bj,
  output logic                  debug_exception,
  output logic [CNT_W-1:0]      perf_flush_cnt,
  output logic [CNT_W-1:0]      perf_bj_cnt
);

  localparam int          DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

  hfc_state_e         state, state_nxt;
  hazard_cause_e      cause;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               load_use;
  logic               any_flush;
  logic               is_bj_d;
  logic               exception_d;

  assign load_use    = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_rs2);
  assign any_flush   = flush_id | flush_ex | flush_mem;
  assign is_bj_d     = ex_is_bj & (state == RUN);
  assign exception_d = (state != RUN) | mem_exception;

  always_comb begin
    state_nxt        = state;
    cause            = NONE;
    stall_if         = 1'b0;
    stall_id         = 1'b0;
    flush_id         = 1'b0;
    flush_ex         = 1'b0;
    flush_mem        = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;

    case (state)
      RUN: begin
        if (mem_exception)    cause = EXC;
        else if (ex_bj_taken) cause = BJ;
        else if (load_use)    cause = LOAD_USE;

        case (cause)
          EXC: begin
            stall_if  = 1'b1;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
            state_nxt = TRAP_DRAIN;
          end
          BJ: begin
            pc_redirect      = 1'b1;
            pc_redirect_addr = ex_bj_target;
            flush_id         = 1'b1;
            flush_ex         = 1'b1;
          end
          LOAD_USE: begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
          default: ;
        endcase
      end

      // Inputs are deliberately ignored while draining the pipe.
      TRAP_DRAIN: begin
        stall_if  = 1'b1;
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
        flush_mem = 1'b1;
        if (drain_cnt == '0) state_nxt = TRAP_REDIRECT;
      end

      TRAP_REDIRECT: begin
        pc_redirect      = 1'b1;
        pc_redirect_addr = TRAP_VECTOR;
        flush_id         = 1'b1;
        state_nxt        = RUN;
      end

      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RUN;
      drain_cnt       <= '0;
      epc             <= '0;
      debug_flush     <= 1'b0;
      debug_is_bj     <= 1'b0;
      debug_exception <= 1'b0;
    end else begin
      state           <= state_nxt;
      debug_flush     <= any_flush;
      debug_is_bj     <= is_bj_d;
      debug_exception <= exception_d;
      if (cause == EXC) begin
        epc       <= mem_pc;
        drain_cnt <= DRAIN_INIT;
      end else if ((state == TRAP_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
    end
  end

`ifdef HFC_PERF_CNT_EN
  hfc_perf_counter #(
    .CNT_W     (CNT_W),
    .EDGE_MODE (1'b1)
  ) u_flush_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .event_in (any_flush),
    .count    (perf_flush_cnt)
  );

  hfc_perf_counter #(
    .CNT_W     (CNT_W),
    .EDGE_MODE (1'b0)
  ) u_bj_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .event_in (is_bj_d),
    .count    (perf_bj_cnt)
  );
`else
  assign perf_flush_cnt = '0;
  assign perf_bj_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_flush_ctrl.sv
// ---- tb_hazard_flush_ctrl : randomized bench for hazard_flush_ctrl with trap-sequence model ---- rev 1.0
`default_nettype none

module tb_hazard_flush_ctrl;

  localparam int          XLEN   = 32;
  localparam int          DRAIN  = 2;
  localparam logic [31:0] TVEC   = 32'h0000_0100;
`ifdef HFC_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, ex_is_bj, ex_bj_taken, mem_exception;
  logic [31:0] ex_bj_target, mem_pc;
  logic        stall_if, stall_id, flush_id, flush_ex, flush_mem, pc_redirect;
  logic [31:0] pc_redirect_addr, epc, perf_flush_cnt, perf_bj_cnt;
  logic        debug_flush, debug_is_bj, debug_exception;

  hazard_flush_ctrl #(
    .XLEN(XLEN), .TRAP_VECTOR(TVEC), .DRAIN_CYCLES(DRAIN), .CNT_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_is_bj(ex_is_bj), .ex_bj_taken(ex_bj_taken),
    .ex_bj_target(ex_bj_target), .mem_exception(mem_exception), .mem_pc(mem_pc),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .flush_ex(flush_ex), .flush_mem(flush_mem), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr), .epc(epc),
    .debug_flush(debug_flush), .debug_is_bj(debug_is_bj), .debug_exception(debug_exception),
    .perf_flush_cnt(perf_flush_cnt), .perf_bj_cnt(perf_bj_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: trap_left counts remaining trap cycles (drain cycles + the redirect cycle).
  int          trap_left;
  logic [31:0] m_epc;
  bit          m_dbg_flush, m_dbg_bj, m_dbg_exc, prev_any;
  logic [31:0] m_pf, m_pb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    trap_left   = 0;
    m_epc       = '0;
    m_dbg_flush = 0;
    m_dbg_bj    = 0;
    m_dbg_exc   = 0;
    prev_any    = 0;
    m_pf        = '0;
    m_pb        = '0;
  endtask

  task automatic drive_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read = 0; ex_is_bj = 0; ex_bj_taken = 0; ex_bj_target = '0;
    mem_exception = 0; mem_pc = '0;
  endtask

  task automatic check_regs();
    check("epc",        epc,             m_epc);
    check("dbg_flush",  32'(debug_flush),     32'(m_dbg_flush));
    check("dbg_is_bj",  32'(debug_is_bj),     32'(m_dbg_bj));
    check("dbg_exc",    32'(debug_exception), 32'(m_dbg_exc));
    check("perf_flush", perf_flush_cnt,  m_pf);
    check("perf_bj",    perf_bj_cnt,     m_pb);
  endtask

  // Called at posedge+1; drives inputs, checks at negedge, advances model.
  task automatic step(input bit mr, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit isbj, input bit taken, input logic [31:0] tgt,
                      input bit exc, input logic [31:0] mpc);
    bit e_si, e_sd, e_fi, e_fe, e_fm, e_pr, lu, any, bj_d;
    logic [31:0] e_pa;
    ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    ex_is_bj = isbj; ex_bj_taken = taken; ex_bj_target = tgt;
    mem_exception = exc; mem_pc = mpc;
    @(negedge clk);
    {e_si, e_sd, e_fi, e_fe, e_fm, e_pr} = '0;
    e_pa = '0;
    lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    if (trap_left == 0) begin
      if (exc) begin
        e_si = 1; e_fi = 1; e_fe = 1; e_fm = 1;
      end else if (taken) begin
        e_pr = 1; e_pa = tgt; e_fi = 1; e_fe = 1;
      end else if (lu) begin
        e_si = 1; e_sd = 1; e_fe = 1;
      end
    end else if (trap_left == 1) begin
      e_pr = 1; e_pa = TVEC; e_fi = 1;
    end else begin
      e_si = 1; e_fi = 1; e_fe = 1; e_fm = 1;
    end
    check("stall_if",  32'(stall_if),    32'(e_si));
    check("stall_id",  32'(stall_id),    32'(e_sd));
    check("flush_id",  32'(flush_id),    32'(e_fi));
    check("flush_ex",  32'(flush_ex),    32'(e_fe));
    check("flush_mem", 32'(flush_mem),   32'(e_fm));
    check("redirect",  32'(pc_redirect), 32'(e_pr));
    check("redir_addr", pc_redirect_addr, e_pa);
    check_regs();

    any  = e_fi | e_fe | e_fm;
    bj_d = isbj && (trap_left == 0);
    if (PERF_EN) begin
      if (any && !prev_any && m_pf != 32'hFFFF_FFFF) m_pf = m_pf + 1;
      if (bj_d && m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
    end
    prev_any    = any;
    m_dbg_flush = any;
    m_dbg_bj    = bj_d;
    m_dbg_exc   = (trap_left != 0) || exc;
    if (trap_left == 0 && exc) begin
      trap_left = DRAIN + 1;
      m_epc     = mpc;
    end else if (trap_left > 0) begin
      trap_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserted between edges: reset must act immediately, without waiting for a clock.
  task automatic do_reset();
    drive_idle();
    reset_n = 0;
    #2;
    model_reset();
    check("rst_redirect", 32'(pc_redirect), 32'd0);
    check("rst_stall_if", 32'(stall_if),    32'd0);
    check("rst_flush_id", 32'(flush_id),    32'd0);
    check_regs();
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  initial begin
    drive_idle();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    idle(2);

    // Load-use on rs2, then ex_rd = x0 which must not stall.
    step(1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step(1, 5'd7, 5'd7, 5'd2, 0, 0, 0, 0, 0);

    // Taken branch, then branch colliding with a load-use.
    step(0, 0, 0, 0, 1, 1, 32'h200, 0, 0);
    idle(1);
    step(1, 5'd3, 5'd3, 5'd3, 1, 1, 32'h340, 0, 0);
    idle(1);

    // Exception trap sequence; a second exception during drain is dropped.
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h84);
    step(0, 0, 0, 0, 1, 1, 32'h500, 1, 32'h9C);
    idle(2);
    check("epc_after_trap", epc, 32'h84);
    check("run_after_trap", 32'(pc_redirect | stall_if | flush_id), 32'd0);
    idle(1);

    // Reset while draining: back to RUN, no trap redirect afterwards.
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hC0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(3);

    // Perf counters: three isolated taken branches and one exception.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 1, 32'h1000 + 32'(i * 16), 0, 0);
      idle(1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h44);
    idle(4);
    check("perf_flush_total", perf_flush_cnt, PERF_EN ? 32'd4 : 32'd0);
    check("perf_bj_total",    perf_bj_cnt,    PERF_EN ? 32'd3 : 32'd0);

    // Randomized traffic with a narrow register range so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      bit isbj;
      isbj = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           isbj, isbj && ($urandom_range(0, 1) == 1), $urandom,
           $urandom_range(0, 15) == 0, $urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
